cam_rgb565_capture: RTL

- Upstream video-input stage.
- Takes the 8-bit camera bus (vsync, href, byte data), already synchronous to `vid_clk`.
- Packs byte pairs into RGB565 pixels and drives the frame-buffer line writer's `v_sync` / `data_valid` / `DATA_in` interface.
- Guarantees exactly `H_RES_PIX` valid pixels per line and at most `V_RES_PIX` lines per frame, padding short lines and truncating long ones, so the line writer's counters never misalign.

---
 rtl/cam_rgb565_capture.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/cam_rgb565_capture.sv
// cam_rgb565_capture
// Video-input stage: registers the 8-bit camera bus, packs byte pairs into
// RGB565 pixels and feeds the frame-buffer line writer. Every accepted line
// delivers exactly H_RES_PIX pixels (short lines padded, long lines
// truncated) and at most V_RES_PIX lines are emitted per frame.
module cam_rgb565_capture #(
    parameter int unsigned H_RES_PIX     = 640,
    parameter int unsigned V_RES_PIX     = 480,
    parameter bit          HI_BYTE_FIRST = 1'b1,
    parameter logic [15:0] PAD_COLOR     = 16'h0000
) (
    input  logic                               vid_clk,
    input  logic                               reset_n,
    input  logic                               cam_vsync,
    input  logic                               cam_href,
    input  logic [7:0]                         cam_data,
    input  logic                               capture_en,
    input  logic                               clear_err,
    output logic                               v_sync,
    output logic                               data_valid,
    output logic [15:0]                        DATA_out,
    output logic [$clog2(V_RES_PIX - 1) - 1:0] line_count,
    output logic                               err_short,
    output logic                               err_long
);

    // Output width of line_count; the internal counter is wide enough to
    // hold V_RES_PIX itself so the "frame full" test never wraps.
    localparam int LC_W = $clog2(V_RES_PIX - 1);
    localparam int LI_W = $clog2(V_RES_PIX + 1);
    localparam int PC_W = $clog2(H_RES_PIX + 1);

    localparam logic [PC_W-1:0] H_MAX = PC_W'(H_RES_PIX);
    localparam logic [LI_W-1:0] V_MAX = LI_W'(V_RES_PIX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_SECOND,
        S_PAD,
        S_EOL,
        S_SKIP
    } state_e;

    // Input pipeline. The FSM works on the second stage (href_d2/data_d2) so
    // that a href rising edge seen on stage 1 lines up with byte 0 arriving
    // on stage 2 in the very next cycle.
    logic       vsync_d1_q, vsync_d2_q;
    logic       href_d1_q, href_d2_q;
    logic [7:0] data_d1_q, data_d2_q;

    state_e            state_q;
    logic              frame_en_q;
    logic              discard_q;
    logic [7:0]        byte0_q;
    logic [PC_W-1:0]   pix_q;
    logic [LI_W-1:0]   line_q;
    logic              v_sync_q;
    logic              data_valid_q;
    logic [15:0]       data_out_q;
    logic              err_short_q;
    logic              err_long_q;

    logic              vsync_rise;
    logic              href_rise;
    logic              frame_en_d;
    logic [PC_W-1:0]   pix_next;
    logic [LI_W-1:0]   line_next;
    logic              pix_full;
    logic              line_room;
    logic              eol_room;
    logic [15:0]       pixel;

    // Register the camera bus and keep a second stage for edge detection.
    always_ff @(posedge vid_clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_d1_q <= 1'b0;
            vsync_d2_q <= 1'b0;
            href_d1_q  <= 1'b0;
            href_d2_q  <= 1'b0;
            data_d1_q  <= 8'h00;
            data_d2_q  <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the
            // previous value of the stage before it, forming a true pipeline.
            vsync_d1_q <= cam_vsync;
            vsync_d2_q <= vsync_d1_q;
            href_d1_q  <= cam_href;
            href_d2_q  <= href_d1_q;
            data_d1_q  <= cam_data;
            data_d2_q  <= data_d1_q;
        end
    end

    assign vsync_rise = vsync_d1_q & ~vsync_d2_q;
    assign href_rise  = href_d1_q & ~href_d2_q;
    assign frame_en_d = vsync_rise ? capture_en : frame_en_q;
    assign pix_next   = pix_q + PC_W'(1);
    assign line_next  = line_q + LI_W'(1);
    assign pix_full   = (pix_q == H_MAX);
    assign line_room  = (line_q < V_MAX);
    assign eol_room   = (line_next < V_MAX);
    assign pixel      = HI_BYTE_FIRST ? {byte0_q, data_d2_q} : {data_d2_q, byte0_q};

    // Line FSM with counters, registered outputs and sticky error flags.
    always_ff @(posedge vid_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            frame_en_q   <= 1'b0;
            discard_q    <= 1'b0;
            byte0_q      <= 8'h00;
            pix_q        <= '0;
            line_q       <= '0;
            v_sync_q     <= 1'b0;
            data_valid_q <= 1'b0;
            data_out_q   <= 16'h0000;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_en_q   <= frame_en_d;
            // Equivalent to vsync_d2 & frame_en, but taken from a flop.
            v_sync_q     <= vsync_d1_q & frame_en_d;

            // NOTE: any set further down is a later non-blocking assignment
            // to the same flag and therefore overrides this clear.
            if (clear_err) begin
                err_short_q <= 1'b0;
                err_long_q  <= 1'b0;
            end

            if (vsync_rise) begin
                state_q   <= S_IDLE;
                pix_q     <= '0;
                line_q    <= '0;
                discard_q <= 1'b0;
                if (state_q == S_FIRST || state_q == S_SECOND || state_q == S_PAD)
                    err_short_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (href_rise) begin
                            state_q <= (frame_en_q && line_room) ? S_FIRST : S_SKIP;
                            if (frame_en_q && !line_room)
                                err_long_q <= 1'b1;
                        end
                    end

                    S_FIRST, S_SECOND: begin
                        if (!href_d2_q) begin
                            // End of line; a dangling byte 0 is simply dropped.
                            if (href_rise) begin
                                discard_q   <= 1'b1;
                                err_short_q <= 1'b1;
                            end
                            if (!pix_full) begin
                                state_q     <= S_PAD;
                                err_short_q <= 1'b1;
                            end else begin
                                state_q <= S_EOL;
                            end
                        end else if (state_q == S_FIRST) begin
                            byte0_q <= data_d2_q;
                            state_q <= S_SECOND;
                        end else begin
                            if (!pix_full) begin
                                data_valid_q <= 1'b1;
                                data_out_q   <= pixel;
                                pix_q        <= pix_next;
                            end else begin
                                err_long_q <= 1'b1;
                            end
                            state_q <= S_FIRST;
                        end
                    end

                    S_PAD: begin
                        data_valid_q <= 1'b1;
                        data_out_q   <= PAD_COLOR;
                        pix_q        <= pix_next;
                        // A line starting while padding cannot be captured.
                        if (href_rise) begin
                            discard_q   <= 1'b1;
                            err_short_q <= 1'b1;
                        end
                        if (pix_next == H_MAX)
                            state_q <= S_EOL;
                    end

                    S_EOL: begin
                        line_q    <= line_next;
                        pix_q     <= '0;
                        discard_q <= 1'b0;
                        if (discard_q) begin
                            state_q <= S_SKIP;
                        end else if (href_rise) begin
                            // A line starting right here is handled as in IDLE.
                            state_q <= (frame_en_q && eol_room) ? S_FIRST : S_SKIP;
                            if (frame_en_q && !eol_room)
                                err_long_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end

                    S_SKIP: begin
                        if (!href_d1_q)
                            state_q <= S_IDLE;
                    end

                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign v_sync     = v_sync_q;
    assign data_valid = data_valid_q;
    assign DATA_out   = data_out_q;
    assign line_count = line_q[LC_W-1:0];
    assign err_short  = err_short_q;
    assign err_long   = err_long_q;

endmodule
